// File: rtl/run_det_sched_if.sv
// Requester-side bus of the run detector scheduler: requests, frames, grants and results.
interface run_det_sched_if #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned ID_W    = $clog2(NREQ),
    parameter int unsigned CNT_W   = $clog2(FRAME_W + 1)
);
    logic [NREQ-1:0]         req;
    logic [NREQ*FRAME_W-1:0] data;
    logic [NREQ-1:0]         gnt;
    logic                    busy;
    logic                    done;
    logic [ID_W-1:0]         res_id;
    logic [FRAME_W-1:0]      res_mask;
    logic [CNT_W-1:0]        res_hits;

    modport master (
        output req, data,
        input  gnt, busy, done, res_id, res_mask, res_hits
    );

    modport slave (
        input  req, data,
        output gnt, busy, done, res_id, res_mask, res_hits
    );
endinterface

// File: rtl/run_det_sched.sv
// Round-robin scheduler sharing one serial 4-equal-bit run detector among NREQ requesters.
// Each granted frame is shifted MSB-first through a freshly cleared detector.
module run_det_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned ID_W    = $clog2(NREQ),
    parameter int unsigned CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic             clk,
    input  logic             nReset,
    run_det_sched_if.slave   bus,
    output logic             det_rst_n,
    output logic             det_in,
    input  logic             det_out
);
    localparam int unsigned IDX_W = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] acc_q, acc_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               det_rst_n_q, det_rst_n_d;
    logic               det_in_q, det_in_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic [FRAME_W-1:0] res_mask_q, res_mask_d;
    logic [CNT_W-1:0]   res_hits_q, res_hits_d;

    logic               found;
    logic [ID_W-1:0]    pick;
    logic [FRAME_W-1:0] frames [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_frames
        assign frames[g] = bus.data[g*FRAME_W +: FRAME_W];
    end

    function automatic logic [CNT_W-1:0] popcnt(input logic [FRAME_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < FRAME_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // First set request at or above the rotation pointer, wrapping around.
    always_comb begin
        int unsigned j;
        j     = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = 32'(rr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req[ID_W'(j)]) begin
                found = 1'b1;
                pick  = ID_W'(j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        gnt_d       = '0;
        done_d      = 1'b0;
        det_rst_n_d = 1'b1;
        det_in_d    = det_in_q;
        res_id_d    = res_id_q;
        res_mask_d  = res_mask_q;
        res_hits_d  = res_hits_q;

        case (state_q)
            ST_IDLE: begin
                det_in_d = 1'b0;
                if (found) begin
                    state_d     = ST_CLEAR;
                    gnt_d[pick] = 1'b1;
                    frame_d     = frames[pick];
                    id_d        = pick;
                    rr_d        = (pick == ID_W'(NREQ - 1)) ? '0 : pick + 1'b1;
                    det_rst_n_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                state_d  = ST_SHIFT;
                det_in_d = frame_q[FRAME_W-1];
                frame_d  = frame_q << 1;
                idx_d    = IDX_W'(FRAME_W - 1);
                acc_d    = '0;
            end
            ST_SHIFT: begin
                // det_out is Mealy on the bit currently presented, so sample before advancing.
                acc_d[idx_q] = det_out;
                det_in_d     = frame_q[FRAME_W-1];
                frame_d      = frame_q << 1;
                idx_d        = idx_q - 1'b1;
                if (idx_q == '0) begin
                    state_d    = ST_REPORT;
                    done_d     = 1'b1;
                    res_id_d   = id_q;
                    res_mask_d = acc_d;
                    res_hits_d = popcnt(acc_d);
                end
            end
            ST_REPORT: begin
                state_d  = ST_IDLE;
                det_in_d = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                det_in_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            frame_q     <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            det_rst_n_q <= 1'b0;
            det_in_q    <= 1'b0;
            res_id_q    <= '0;
            res_mask_q  <= '0;
            res_hits_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            det_rst_n_q <= det_rst_n_d;
            det_in_q    <= det_in_d;
            res_id_q    <= res_id_d;
            res_mask_q  <= res_mask_d;
            res_hits_q  <= res_hits_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.res_id   = res_id_q;
    assign bus.res_mask = res_mask_q;
    assign bus.res_hits = res_hits_q;
    assign det_rst_n    = det_rst_n_q;
    assign det_in       = det_in_q;

endmodule

// File: tb/tb_run_det_sched.sv
// Bench for run_det_sched: behavioural run detector, expected grants/results queued at stimulus time.
module tb_run_det_sched;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned FRAME_W = 8;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned CNT_W   = 4;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic det_rst_n, det_in, det_out;

    always #5 clk = ~clk;

    run_det_sched_if #(.NREQ(NREQ), .FRAME_W(FRAME_W), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    run_det_sched #(.NREQ(NREQ), .FRAME_W(FRAME_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .bus       (bus.slave),
        .det_rst_n (det_rst_n),
        .det_in    (det_in),
        .det_out   (det_out)
    );

    // Mealy detector: high on the 4th and later consecutive equal bits since reset.
    logic [1:0] dcnt;
    logic       dlast;
    assign det_out = (dcnt == 2'd3) && (det_in == dlast);
    always_ff @(posedge clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            dcnt  <= 2'd0;
            dlast <= 1'b0;
        end else if (dcnt == 2'd0 || det_in != dlast) begin
            dcnt  <= 2'd1;
            dlast <= det_in;
        end else if (dcnt != 2'd3) begin
            dcnt <= dcnt + 2'd1;
        end
    end

    typedef struct {
        int         id;
        logic [7:0] mask;
        int         hits;
    } res_t;

    res_t rq[$];
    int   gq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   gnt_cnt = 0;
    int   done_cnt = 0;
    int   last_gnt_cyc = 0;
    int   last_done_cyc = -1;
    bit   gap_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_mask(input logic [7:0] f);
        logic [7:0] m;
        int         run;
        logic       prev;
        m = 8'h00;
        run = 0;
        prev = ~f[7];
        for (int i = 7; i >= 0; i--) begin
            run  = (f[i] == prev) ? run + 1 : 1;
            prev = f[i];
            m[i] = (run >= 4);
        end
        return m;
    endfunction

    function automatic int count_ones(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic expect_frame(input int id, input logic [7:0] f);
        res_t r;
        r.id   = id;
        r.mask = exp_mask(f);
        r.hits = count_ones(r.mask);
        gq.push_back(id);
        rq.push_back(r);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: grants and results popped from the scoreboard as they appear.
    always @(negedge clk) begin
        if (nReset && bus.gnt != '0) begin
            int gid;
            gid = 0;
            for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) gid = i;
            chk("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
            if (gq.size() == 0) chk("gnt_unexpected", 32'(gid), 32'hFFFF_FFFF);
            else chk("gnt_id", 32'(gid), 32'(gq.pop_front()));
            last_gnt_cyc = cyc;
            gnt_cnt++;
        end
        if (nReset && bus.done) begin
            chk("done_latency", 32'(cyc - last_gnt_cyc), 32'd9);
            if (gap_en && last_done_cyc >= 0) chk("done_gap", 32'(cyc - last_done_cyc), 32'd11);
            last_done_cyc = cyc;
            if (rq.size() == 0) begin
                chk("done_unexpected", 32'(bus.res_id), 32'hFFFF_FFFF);
            end else begin
                res_t r;
                r = rq.pop_front();
                chk("res_id", 32'(bus.res_id), 32'(r.id));
                chk("res_mask", 32'(bus.res_mask), 32'(r.mask));
                chk("res_hits", 32'(bus.res_hits), 32'(r.hits));
            end
            done_cnt++;
        end
    end

    task automatic wait_gnts(input int n);
        int t;
        t = 0;
        while (gnt_cnt < n && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (gnt_cnt < n) chk("gnt_timeout", 32'(gnt_cnt), 32'(n));
    endtask

    task automatic wait_dones(input int n);
        int t;
        t = 0;
        while (done_cnt < n && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_cnt < n) chk("done_timeout", 32'(done_cnt), 32'(n));
    endtask

    task automatic run_frame(input int id, input logic [7:0] f);
        int g0, d0;
        g0 = gnt_cnt;
        d0 = done_cnt;
        bus.data[id*FRAME_W +: FRAME_W] = f;
        expect_frame(id, f);
        bus.req[id] = 1'b1;
        wait_gnts(g0 + 1);
        bus.req[id] = 1'b0;
        wait_dones(d0 + 1);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        nReset  = 1'b0;
        bus.req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nReset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},       32'(bus.gnt),      32'd0);
        chk({tag, "_busy"},      32'(bus.busy),     32'd0);
        chk({tag, "_done"},      32'(bus.done),     32'd0);
        chk({tag, "_det_rst_n"}, 32'(det_rst_n),    32'd0);
        chk({tag, "_det_in"},    32'(det_in),       32'd0);
        chk({tag, "_res_id"},    32'(bus.res_id),   32'd0);
        chk({tag, "_res_mask"},  32'(bus.res_mask), 32'd0);
        chk({tag, "_res_hits"},  32'(bus.res_hits), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, d0;
        bus.req  = '0;
        bus.data = '0;

        #2;
        check_reset_outputs("por");
        @(negedge clk);
        nReset = 1'b1;
        @(posedge clk); #1;
        chk("det_rst_n_release", 32'(det_rst_n), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Single requester, then the result-producing frame before a mid-frame reset.
        run_frame(0, 8'h0F);
        chk("hold_mask", 32'(bus.res_mask), 32'h11);

        // Mid-frame reset abandons the frame and clears everything.
        bus.data[0 +: FRAME_W] = 8'h0F;
        gq.push_back(0);
        g0 = gnt_cnt;
        bus.req[0] = 1'b1;
        wait_gnts(g0 + 1);
        bus.req[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("busy_in_shift", 32'(bus.busy), 32'd1);
        d0 = done_cnt;
        nReset = 1'b0;
        #1;
        check_reset_outputs("mid");
        repeat (3) @(posedge clk);
        @(negedge clk);
        nReset = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("no_done_after_abort", 32'(done_cnt), 32'(d0));
        run_frame(0, 8'h0F);

        // Pattern sweep on requester 2.
        run_frame(2, 8'h00);
        run_frame(2, 8'hFF);
        run_frame(2, 8'h55);
        run_frame(2, 8'hC3);

        // Back-to-back frames from one requester: no history carried across CLEAR.
        g0 = gnt_cnt;
        d0 = done_cnt;
        bus.data[1*FRAME_W +: FRAME_W] = 8'hFF;
        expect_frame(1, 8'hFF);
        expect_frame(1, 8'h00);
        bus.req[1] = 1'b1;
        wait_gnts(g0 + 1);
        bus.data[1*FRAME_W +: FRAME_W] = 8'h00;
        wait_gnts(g0 + 2);
        bus.req[1] = 1'b0;
        wait_dones(d0 + 2);

        // All four requesting: strict rotation from pointer 0, dones 11 cycles apart.
        apply_reset();
        bus.data = {8'hF0, 8'hAA, 8'h3C, 8'h87};
        expect_frame(0, 8'h87);
        expect_frame(1, 8'h3C);
        expect_frame(2, 8'hAA);
        expect_frame(3, 8'hF0);
        expect_frame(0, 8'h87);
        g0 = gnt_cnt;
        d0 = done_cnt;
        gap_en = 1'b1;
        last_done_cyc = -1;
        bus.req = 4'b1111;
        wait_gnts(g0 + 5);
        bus.req = '0;
        wait_dones(d0 + 5);
        gap_en = 1'b0;

        // Pointer wrap: after a grant to 3, requester 0 goes before 3.
        run_frame(3, 8'h1E);
        g0 = gnt_cnt;
        d0 = done_cnt;
        bus.data[0*FRAME_W +: FRAME_W] = 8'hF8;
        bus.data[3*FRAME_W +: FRAME_W] = 8'h0F;
        expect_frame(0, 8'hF8);
        expect_frame(3, 8'h0F);
        bus.req = 4'b1001;
        wait_gnts(g0 + 1);
        bus.req[0] = 1'b0;
        wait_gnts(g0 + 2);
        bus.req[3] = 1'b0;
        wait_dones(d0 + 2);

        repeat (4) begin @(posedge clk); #1; end
        chk("result_queue_empty", 32'(rq.size()), 32'd0);
        chk("grant_queue_empty", 32'(gq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
